datapath_ctrl_seq: RTL and testbench

- Hardwired control sequencer for the phase-2 bus datapath.
- Steps each instruction through fetch (T0–T2), decode and execute (T3–T6).
- Drives every datapath strobe: register in/out selects, ALU op select, memory Read, IncPC.
- Sits beside the datapath. It reads the IR value back from the datapath and handshakes with memory through mem_ready.

---
 rtl/datapath_ctrl_seq_pkg.sv | 55 +++++
 rtl/datapath_ctrl_seq_if.sv | 28 ++
 rtl/datapath_ctrl_seq_decode.sv | 35 +++
 rtl/datapath_ctrl_seq.sv | 194 +++++++++++++++++++
 tb/tb_datapath_ctrl_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_ctrl_seq_pkg.sv
// Shared definitions for the datapath control sequencer: opcodes, IR field
// positions, ALU one-hot bit indices, state and instruction-class encodings.
package ctrl_pkg;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  localparam int ALU_W   = 12;
  localparam int ALU_ADD = 11;
  localparam int ALU_SUB = 10;
  localparam int ALU_MUL = 9;
  localparam int ALU_DIV = 8;
  localparam int ALU_SHR = 7;
  localparam int ALU_SHL = 6;
  localparam int ALU_ROR = 5;
  localparam int ALU_ROL = 4;
  localparam int ALU_AND = 3;
  localparam int ALU_OR  = 2;
  localparam int ALU_NEG = 1;
  localparam int ALU_NOT = 0;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_STEP_WAIT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU3, CLS_MULDIV, CLS_UNARY, CLS_HALT
  } op_class_t;

  function automatic logic [ALU_W-1:0] alu_bit(input int idx);
    return ALU_W'(1) << idx;
  endfunction

endpackage

// File: rtl/datapath_ctrl_seq_if.sv
// Sequencer <-> datapath/memory bundle: IR readback, memory handshake and
// every datapath strobe. master = sequencer, slave = datapath.
interface datapath_ctrl_seq_if
  import ctrl_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16
);
  logic                 mem_ready;
  logic [BITS-1:0]      ir;
  logic [REGISTERS-1:0] GPRin;
  logic [REGISTERS-1:0] GPRout;
  logic [ALU_W-1:0]     alu_op;
  logic PCin, PCout, IRin, MARin, MDRin, MDRout, Read;
  logic RYin, RZin, Zlowout, Zhighout, HIin, LOin, IncPC;

  modport master (
    input  mem_ready, ir,
    output GPRin, GPRout, alu_op, PCin, PCout, IRin, MARin, MDRin, MDRout,
           Read, RYin, RZin, Zlowout, Zhighout, HIin, LOin, IncPC
  );

  modport slave (
    output mem_ready, ir,
    input  GPRin, GPRout, alu_op, PCin, PCout, IRin, MARin, MDRin, MDRout,
           Read, RYin, RZin, Zlowout, Zhighout, HIin, LOin, IncPC
  );
endinterface

// File: rtl/datapath_ctrl_seq_decode.sv
// Combinational opcode decode: instruction class, ALU one-hot select and
// undefined-opcode flag. Undefined opcodes fall into the nop class.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0]       op,
  output op_class_t        op_class,
  output logic [ALU_W-1:0] alu_op,
  output logic             illegal
);

  always_comb begin
    op_class = CLS_NOP;
    alu_op   = '0;
    illegal  = 1'b0;
    case (op)
      OP_ADD:  begin op_class = CLS_ALU3;   alu_op = alu_bit(ALU_ADD); end
      OP_SUB:  begin op_class = CLS_ALU3;   alu_op = alu_bit(ALU_SUB); end
      OP_SHR:  begin op_class = CLS_ALU3;   alu_op = alu_bit(ALU_SHR); end
      OP_SHL:  begin op_class = CLS_ALU3;   alu_op = alu_bit(ALU_SHL); end
      OP_ROR:  begin op_class = CLS_ALU3;   alu_op = alu_bit(ALU_ROR); end
      OP_ROL:  begin op_class = CLS_ALU3;   alu_op = alu_bit(ALU_ROL); end
      OP_AND:  begin op_class = CLS_ALU3;   alu_op = alu_bit(ALU_AND); end
      OP_OR:   begin op_class = CLS_ALU3;   alu_op = alu_bit(ALU_OR);  end
      OP_MUL:  begin op_class = CLS_MULDIV; alu_op = alu_bit(ALU_MUL); end
      OP_DIV:  begin op_class = CLS_MULDIV; alu_op = alu_bit(ALU_DIV); end
      OP_NEG:  begin op_class = CLS_UNARY;  alu_op = alu_bit(ALU_NEG); end
      OP_NOT:  begin op_class = CLS_UNARY;  alu_op = alu_bit(ALU_NOT); end
      OP_NOP:  op_class = CLS_NOP;
      OP_HALT: op_class = CLS_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl_seq.sv
// Hardwired fetch/decode/execute sequencer driving the phase-2 datapath strobes.
// Optional single-step mode: define CTRL_SINGLE_STEP_EN (adds `step`, STEP_WAIT).
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | after reset, no strobes; start level begins fetch
//   T0        | PC -> MAR, PC+1 -> Z
//   T1        | Z -> PC, memory read into MDR; holds until mem_ready
//   T2        | MDR -> IR
//   T3        | decode ir, latch fields, first execute step
//   T4..T6    | remaining execute steps, decoded from latched fields
//   HALT      | halted; needs a rising edge on start to resume
//   STEP_WAIT | single-step only: waits for a rising edge on step
module datapath_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16
)(
  input  logic Clock,
  input  logic reset,
  input  logic start,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic step,
`endif
  datapath_ctrl_seq_if.master dp,
  output logic busy,
  output logic halted,
  output logic illegal
);

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t S_AFTER = S_STEP_WAIT;
`else
  localparam state_t S_AFTER = S_T0;
`endif

  state_t           state, state_nx;
  logic             start_q;
  logic [4:0]       op_q;
  logic [3:0]       ra_q, rb_q, rc_q;
  logic [4:0]       op_sel;
  logic [3:0]       ra_sel, rb_sel;
  op_class_t        dec_class;
  logic [ALU_W-1:0] dec_alu;
  logic             dec_illegal;
  logic [BITS-1:0]  ir_w;
  logic             unused_ir_bits;

  assign ir_w           = dp.ir;
  assign unused_ir_bits = ^ir_w[RC_LO-1:0];

  // T3 decodes straight from ir; later steps use the fields latched at T3.
  assign op_sel = (state == S_T3) ? ir_w[OP_HI:OP_LO] : op_q;
  assign ra_sel = (state == S_T3) ? ir_w[RA_HI:RA_LO] : ra_q;
  assign rb_sel = (state == S_T3) ? ir_w[RB_HI:RB_LO] : rb_q;

  ctrl_decode u_decode (
    .op       (op_sel),
    .op_class (dec_class),
    .alu_op   (dec_alu),
    .illegal  (dec_illegal)
  );

  function automatic logic [REGISTERS-1:0] gpr_sel(input logic [3:0] idx);
    return REGISTERS'(1) << idx;
  endfunction

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= start;
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
    end else if (state == S_T3) begin
      op_q <= ir_w[OP_HI:OP_LO];
      ra_q <= ir_w[RA_HI:RA_LO];
      rb_q <= ir_w[RB_HI:RB_LO];
      rc_q <= ir_w[RC_HI:RC_LO];
    end
  end

`ifdef CTRL_SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end
`endif

  always_comb begin
    state_nx    = state;
    dp.GPRin    = '0;
    dp.GPRout   = '0;
    dp.alu_op   = '0;
    dp.PCin     = 1'b0;
    dp.PCout    = 1'b0;
    dp.IRin     = 1'b0;
    dp.MARin    = 1'b0;
    dp.MDRin    = 1'b0;
    dp.MDRout   = 1'b0;
    dp.Read     = 1'b0;
    dp.RYin     = 1'b0;
    dp.RZin     = 1'b0;
    dp.Zlowout  = 1'b0;
    dp.Zhighout = 1'b0;
    dp.HIin     = 1'b0;
    dp.LOin     = 1'b0;
    dp.IncPC    = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_T0;
      S_HALT: if (start && !start_q) state_nx = S_T0;
      S_T0: begin
        dp.PCout = 1'b1; dp.MARin = 1'b1; dp.IncPC = 1'b1; dp.RZin = 1'b1;
        state_nx = S_T1;
      end
      S_T1: begin
        dp.Zlowout = 1'b1; dp.PCin = 1'b1; dp.Read = 1'b1; dp.MDRin = 1'b1;
        if (dp.mem_ready) state_nx = S_T2;
      end
      S_T2: begin
        dp.MDRout = 1'b1; dp.IRin = 1'b1;
        state_nx  = S_T3;
      end
      S_T3: begin
        illegal = dec_illegal;
        case (dec_class)
          CLS_ALU3: begin
            dp.GPRout = gpr_sel(rb_sel); dp.RYin = 1'b1; state_nx = S_T4;
          end
          CLS_MULDIV: begin
            dp.GPRout = gpr_sel(ra_sel); dp.RYin = 1'b1; state_nx = S_T4;
          end
          CLS_UNARY: begin
            dp.GPRout = gpr_sel(rb_sel); dp.alu_op = dec_alu; dp.RZin = 1'b1;
            state_nx  = S_T4;
          end
          CLS_HALT: state_nx = S_HALT;
          default:  state_nx = S_AFTER;
        endcase
      end
      S_T4: begin
        case (dec_class)
          CLS_ALU3: begin
            dp.GPRout = gpr_sel(rc_q); dp.alu_op = dec_alu; dp.RZin = 1'b1;
            state_nx  = S_T5;
          end
          CLS_MULDIV: begin
            dp.GPRout = gpr_sel(rb_q); dp.alu_op = dec_alu; dp.RZin = 1'b1;
            state_nx  = S_T5;
          end
          CLS_UNARY: begin
            dp.Zlowout = 1'b1; dp.GPRin = gpr_sel(ra_q); state_nx = S_AFTER;
          end
          default: state_nx = S_T0;
        endcase
      end
      S_T5: begin
        case (dec_class)
          CLS_ALU3: begin
            dp.Zlowout = 1'b1; dp.GPRin = gpr_sel(ra_q); state_nx = S_AFTER;
          end
          CLS_MULDIV: begin
            dp.Zlowout = 1'b1; dp.LOin = 1'b1; state_nx = S_T6;
          end
          default: state_nx = S_T0;
        endcase
      end
      S_T6: begin
        dp.Zhighout = 1'b1; dp.HIin = 1'b1;
        state_nx    = S_AFTER;
      end
`ifdef CTRL_SINGLE_STEP_EN
      S_STEP_WAIT: if (step && !step_q) state_nx = S_T0;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_datapath_ctrl_seq.sv
// Scoreboard bench for datapath_ctrl_seq: the stimulus pushes per-cycle expected
// strobe sets built from the instruction-class tables; a monitor pops and compares.
module tb_datapath_ctrl_seq;

  typedef struct packed {
    logic [15:0] gin;
    logic [15:0] gout;
    logic [11:0] alu;
    logic [13:0] strb;
    logic        busy;
    logic        halted;
    logic        illegal;
  } obs_t;

  localparam logic [13:0] M_PCIN   = 14'h2000;
  localparam logic [13:0] M_PCOUT  = 14'h1000;
  localparam logic [13:0] M_IRIN   = 14'h0800;
  localparam logic [13:0] M_MARIN  = 14'h0400;
  localparam logic [13:0] M_MDRIN  = 14'h0200;
  localparam logic [13:0] M_MDROUT = 14'h0100;
  localparam logic [13:0] M_READ   = 14'h0080;
  localparam logic [13:0] M_RYIN   = 14'h0040;
  localparam logic [13:0] M_RZIN   = 14'h0020;
  localparam logic [13:0] M_ZLO    = 14'h0010;
  localparam logic [13:0] M_ZHI    = 14'h0008;
  localparam logic [13:0] M_HIIN   = 14'h0004;
  localparam logic [13:0] M_LOIN   = 14'h0002;
  localparam logic [13:0] M_INCPC  = 14'h0001;

  localparam int K_NOP = 0, K_ALU3 = 1, K_MULDIV = 2, K_UNARY = 3, K_HALT = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic step_drv;
  logic busy, halted, illegal;
  bit   st_random;
  logic st_level;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  datapath_ctrl_seq_if #(.BITS(32), .REGISTERS(16)) dpi();

  datapath_ctrl_seq #(.BITS(32), .REGISTERS(16)) dut (
    .Clock   (clk),
    .reset   (rst),
    .start   (start),
`ifdef CTRL_SINGLE_STEP_EN
    .step    (step_drv),
`endif
    .dp      (dpi.master),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Reference tables: instruction class and ALU select for each opcode.
  function automatic int klass(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: return K_ALU3;
      5'b01110, 5'b01111:                     return K_MULDIV;
      5'b10000, 5'b10001:                     return K_UNARY;
      5'b11001:                               return K_HALT;
      default:                                return K_NOP;
    endcase
  endfunction

  function automatic logic [11:0] alu_mask(input logic [4:0] op);
    case (op)
      5'b00011: return 12'h800;
      5'b00100: return 12'h400;
      5'b01110: return 12'h200;
      5'b01111: return 12'h100;
      5'b00101: return 12'h080;
      5'b00110: return 12'h040;
      5'b00111: return 12'h020;
      5'b01000: return 12'h010;
      5'b01001: return 12'h008;
      5'b01010: return 12'h004;
      5'b10000: return 12'h002;
      5'b10001: return 12'h001;
      default:  return 12'h000;
    endcase
  endfunction

  function automatic bit is_illegal(input logic [4:0] op);
    return (klass(op) == K_NOP) && (op != 5'b11000);
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] r);
    return 16'(1) << r;
  endfunction

  function automatic obs_t mk(input logic [13:0] s, input logic [15:0] gi,
                              input logic [15:0] go, input logic [11:0] al,
                              input logic il);
    obs_t o;
    o.gin = gi; o.gout = go; o.alu = al; o.strb = s;
    o.busy = 1'b1; o.halted = 1'b0; o.illegal = il;
    return o;
  endfunction

  function automatic obs_t halt_obs();
    obs_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o.gin  = dpi.GPRin;
    o.gout = dpi.GPRout;
    o.alu  = dpi.alu_op;
    o.strb = {dpi.PCin, dpi.PCout, dpi.IRin, dpi.MARin, dpi.MDRin, dpi.MDRout,
              dpi.Read, dpi.RYin, dpi.RZin, dpi.Zlowout, dpi.Zhighout,
              dpi.HIin, dpi.LOin, dpi.IncPC};
    o.busy = busy; o.halted = halted; o.illegal = illegal;
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got gin=%h gout=%h alu=%h strb=%b bhi=%b%b%b, expected gin=%h gout=%h alu=%h strb=%b bhi=%b%b%b",
                 t, $time, a.gin, a.gout, a.alu, a.strb, a.busy, a.halted, a.illegal,
                 e.gin, e.gout, e.alu, e.strb, e.busy, e.halted, e.illegal);
      end
    end
  end

  function automatic logic rmr();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic mr, input logic [31:0] irv, input obs_t e, input string tag);
    dpi.mem_ready = mr;
    dpi.ir        = irv;
    start         = st_random ? 1'($urandom_range(0, 1)) : st_level;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rc, input int waits, input bit scramble,
                           input bit rst_t4, input int step_wait);
    logic [31:0] irv, ir_late;
    logic [11:0] a;
    int k;
    irv = {op, ra, rb, rc, 15'($urandom)};
    k   = klass(op);
    a   = alu_mask(op);
    cyc(rmr(), irv, mk(M_PCOUT | M_MARIN | M_INCPC | M_RZIN, 0, 0, 0, 0), "T0");
    for (int i = 0; i <= waits; i++)
      cyc(i == waits, irv, mk(M_ZLO | M_PCIN | M_READ | M_MDRIN, 0, 0, 0, 0), "T1");
    cyc(rmr(), irv, mk(M_MDROUT | M_IRIN, 0, 0, 0, 0), "T2");
    ir_late = scramble ? $urandom : irv;
    case (k)
      K_ALU3: begin
        cyc(rmr(), irv, mk(M_RYIN, 0, oh(rb), 0, 0), "alu3_T3");
        if (rst_t4) begin
          rst = 1'b0;
          cyc(rmr(), ir_late, '0, "reset_mid_T4");
          return;
        end
        cyc(rmr(), ir_late, mk(M_RZIN, 0, oh(rc), a, 0), "alu3_T4");
        cyc(rmr(), ir_late, mk(M_ZLO, oh(ra), 0, 0, 0), "alu3_T5");
      end
      K_MULDIV: begin
        cyc(rmr(), irv, mk(M_RYIN, 0, oh(ra), 0, 0), "muldiv_T3");
        cyc(rmr(), ir_late, mk(M_RZIN, 0, oh(rb), a, 0), "muldiv_T4");
        cyc(rmr(), ir_late, mk(M_ZLO | M_LOIN, 0, 0, 0, 0), "muldiv_T5");
        cyc(rmr(), ir_late, mk(M_ZHI | M_HIIN, 0, 0, 0, 0), "muldiv_T6");
      end
      K_UNARY: begin
        cyc(rmr(), irv, mk(M_RZIN, 0, oh(rb), a, 0), "unary_T3");
        cyc(rmr(), ir_late, mk(M_ZLO, oh(ra), 0, 0, 0), "unary_T4");
      end
      K_HALT: begin
        cyc(rmr(), irv, mk(0, 0, 0, 0, 0), "halt_T3");
        return;
      end
      default: cyc(rmr(), irv, mk(0, 0, 0, 0, is_illegal(op)), "nop_T3");
    endcase
`ifdef CTRL_SINGLE_STEP_EN
    step_drv = 1'b0;
    for (int i = 0; i < step_wait; i++)
      cyc(rmr(), ir_late, mk(0, 0, 0, 0, 0), "step_wait");
    step_drv = 1'b1;
    cyc(rmr(), ir_late, mk(0, 0, 0, 0, 0), "step_edge");
    step_drv = 1'b0;
`else
    if (step_wait < 0) $display("unexpected step_wait %0d", step_wait);
`endif
  endtask

  logic [4:0] legal_ops[13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                5'b01000, 5'b01001, 5'b01010, 5'b01110, 5'b01111,
                                5'b10000, 5'b10001, 5'b11000};

  initial begin
    rst = 1'b0; start = 1'b0; step_drv = 1'b0;
    dpi.mem_ready = 1'b0; dpi.ir = '0;
    st_random = 1'b0; st_level = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(rmr(), $urandom, '0, "in_reset");
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cyc(rmr(), $urandom, '0, "idle_after_reset");
    st_level = 1'b1;
    cyc(rmr(), $urandom, '0, "idle_start");
    st_random = 1'b1;

    run_instr(5'b00011, 4'd2, 4'd3, 4'd4, 0, 0, 0, 0);   // add R2,R3,R4
    run_instr(5'b00011, 4'd2, 4'd3, 4'd4, 3, 0, 0, 0);   // same with memory wait
    run_instr(5'b01110, 4'd5, 4'd6, 4'd0, 0, 1, 0, 0);   // mul R5,R6
    run_instr(5'b00011, 4'd7, 4'd7, 4'd7, 1, 0, 0, 0);   // Ra=Rb=Rc

    // Reset mid-T4 of an add, then stay idle without start
    run_instr(5'b00011, 4'd1, 4'd2, 4'd3, 0, 0, 1, 0);
    cyc(rmr(), $urandom, '0, "reset_held");
    rst = 1'b1;
    st_random = 1'b0; st_level = 1'b0;
    for (int i = 0; i < 4; i++) cyc(rmr(), $urandom, '0, "idle_no_start");
    st_level = 1'b1;
    cyc(rmr(), $urandom, '0, "idle_start2");
    st_random = 1'b1;

    run_instr(5'b11111, 4'd3, 4'd4, 4'd5, 0, 0, 0, 0);   // undefined opcode
    run_instr(5'b10001, 4'd1, 4'd7, 4'd0, 0, 1, 0, 10);  // not R1,R7

    for (int n = 0; n < 120; n++) begin
      logic [4:0] op;
      if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 12)];
      else                          op = 5'($urandom);
      if (op == 5'b11001) op = 5'b11000;
      run_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 0, $urandom_range(0, 2));
    end

    // halt with start held high: no resume until start falls and rises again
    st_random = 1'b0; st_level = 1'b1;
    run_instr(5'b11001, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(rmr(), $urandom, halt_obs(), "halt_start_held");
    st_level = 1'b0;
    for (int i = 0; i < 2; i++) cyc(rmr(), $urandom, halt_obs(), "halt_start_low");
    st_level = 1'b1;
    cyc(rmr(), $urandom, halt_obs(), "halt_start_edge");
    st_random = 1'b1;
    run_instr(5'b01111, 4'd9, 4'd10, 4'd0, 2, 1, 0, 1);  // div resumes at T0

    st_random = 1'b0; st_level = 1'b0;
    run_instr(5'b11001, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(rmr(), $urandom, halt_obs(), "halt_final");

    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
